md5core_result_collector: RTL and testbench
===========================================

# md5core_result_collector

Receiving end of the md5core result output port. Captures each 4-word result burst (dout/dout_en with ctx/seq tags), holds up to two complete results in a ping-pong buffer, and presents them word-by-word to the downstream packet builder through a valid/read-enable handshake. md5core cannot be stalled, so the block reports free-slot count upstream and flags overflow and protocol errors.

## Interface

Parameters:
- RESULT_WORDS, default 4: words per result burst. Must be a power of 2, at least 2. Counter width is log2(RESULT_WORDS).

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- dout  in  32  result word from md5core.
- dout_en  in  1  result word valid.
- dout_seq_num  in  1  sequence tag; sampled on the first word of a burst.
- dout_ctx_num  in  1  context tag; sampled on the first word of a burst.
- out_dout  out  32  current output word.
- out_valid  out  1  a complete result is available.
- out_last  out  1  out_dout is the final word of the result.
- out_ctx_num  out  1  context tag of the result being output.
- out_seq_num  out  1  sequence tag of the result being output.
- out_rd_en  in  1  downstream accepts out_dout this cycle.
- slots_free  out  2  free slots: 0, 1 or 2.
- err_overflow  out  1  sticky; a burst was dropped because no slot was free.
- err_burst  out  1  sticky; a burst was truncated.

## Operation

- Storage: two slots, each holding RESULT_WORDS × 32-bit words plus ctx and seq tags and a full flag. wr_slot and rd_slot pointers each toggle 0↔1.
- Write FSM states:
  - IDLE: on dout_en, if slot[wr_slot] is free (or is being freed this cycle), store word 0, latch ctx/seq, wr_cnt←1, go to FILL. Otherwise go to DROP and set err_overflow.
  - FILL: on dout_en, store word wr_cnt and increment. On the last word, set full, toggle wr_slot, go to IDLE.
    - dout_en low while in FILL: discard the partial result (slot stays free), set err_burst, go to IDLE.
    - ctx/seq changes mid-burst are ignored.
  - DROP: count RESULT_WORDS−1 further dout_en cycles, then go to IDLE. A gap in dout_en sets err_burst and returns to IDLE.
- Read side:
  - out_valid = slot[rd_slot].full.
  - out_dout = slot[rd_slot].word[rd_cnt].
  - out_last = out_valid & (rd_cnt == RESULT_WORDS−1).
  - A transfer occurs on out_valid & out_rd_en; rd_cnt increments. On the last transfer, clear full, reset rd_cnt to 0 and toggle rd_slot.
  - out_rd_en while out_valid is low is ignored.
- slots_free = 2 − (number of full slots), registered. A slot that is filling counts as free until its last word.
- Error flags clear only on reset.

## Timing

- Reset values: out_valid 0, out_last 0, out_dout 0, out_ctx_num 0, out_seq_num 0, slots_free 2, both error flags 0, pointers 0, write FSM in IDLE.
- Reset is asynchronous; asserting it mid-burst or mid-read discards all contents.
- Latency: the last input word is written on edge N; out_valid rises after edge N, i.e. in cycle N+1 (one cycle).
- Back-to-back bursts with no idle cycle between them are accepted into alternate slots.
- Simultaneous last read of slot X and first write into slot X: the write is accepted (free bypass), with no overflow.
- slots_free reflects full-flag updates one cycle after the causing edge.
- Downstream sustains one word per cycle; a full result drains in RESULT_WORDS cycles when out_rd_en is held high.

## Structure

- md5.vh (shared header): RESULT_WORDS default and a slot-count constant (2).
- Sub-module md5_result_buf: the two-slot word RAM with tag and full registers, one write port and one read port (distributed RAM). The write FSM and read counter stay in the top level.

## Test plan

- Single burst: 4d5d219e, 0a38ffaf, 87e11a6d, 9aef84fa with ctx0/seq0, out_rd_en held high.
  - Required: out_valid rises 1 cycle after the last input word; the 4 words appear in order; out_last on the 4th word; slots_free goes 2→1→2.
- Two back-to-back bursts (ctx0/seq0, then ctx1/seq1 with 40593c8c as word 0), out_rd_en low.
  - Required: slots_free=0; releasing out_rd_en yields both results in order with the correct tags.
- Third burst while both slots are full.
  - Required: err_overflow=1; the stored results are unchanged; the next burst after a drain is accepted.
- Burst with dout_en dropping after word 2.
  - Required: err_burst=1; no out_valid; slots_free stays 2.
- Last read of slot 0 in the same cycle as word 0 of a new burst into slot 0.
  - Required: no overflow; the new result is output correctly.
- RST_N pulsed low mid-burst.
  - Required: all outputs return to reset values immediately; the next full burst is collected normally.

Source files
------------

// File: rtl/md5core_result_collector_pkg.sv
// Shared constants and types for the md5core result collector.
package md5core_result_collector_pkg;

  localparam int unsigned RESULT_WORDS_DEF = 4;
  localparam int unsigned SLOT_COUNT       = 2;
  localparam int unsigned SLOT_W           = 1;
  localparam int unsigned WORD_W           = 32;
  localparam int unsigned FREE_W           = 2;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_FILL = 2'd1,
    WR_DROP = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic ctx;
    logic seq;
  } result_tag_t;

endpackage

// File: rtl/md5core_result_collector_buf.sv
// Two-slot result store: word RAM, per-slot tags and full flags.
module md5_result_buf
  import md5core_result_collector_pkg::*;
#(
  parameter int unsigned RESULT_WORDS = RESULT_WORDS_DEF,
  localparam int unsigned CNT_W = $clog2(RESULT_WORDS)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              wr_en,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic [CNT_W-1:0]  wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              tag_en,
  input  result_tag_t       wr_tag,
  input  logic              set_full,
  input  logic              clr_full,
  input  logic [SLOT_W-1:0] rd_slot,
  input  logic [CNT_W-1:0]  rd_addr,
  output logic [WORD_W-1:0] rd_data_c,
  output result_tag_t       rd_tag_c,
  output logic [SLOT_COUNT-1:0] full
);

  logic [WORD_W-1:0] mem_q [SLOT_COUNT][RESULT_WORDS];
  result_tag_t       tag_q [SLOT_COUNT];
  logic [SLOT_COUNT-1:0] full_d;

  // Word and tag storage; cleared on reset so the output port reads zero.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem_q <= '{default: '0};
      tag_q <= '{default: '0};
    end else begin
      if (wr_en) mem_q[wr_slot][wr_addr] <= wr_data;
      if (tag_en) tag_q[wr_slot] <= wr_tag;
    end
  end

  // Full-flag next value; set and clear never target the same slot together.
  always_comb begin
    full_d = full;
    if (clr_full) full_d[rd_slot] = 1'b0;
    if (set_full) full_d[wr_slot] = 1'b1;
  end

  // Full-flag register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) full <= '0;
    else        full <= full_d;
  end

  assign rd_data_c = mem_q[rd_slot][rd_addr];
  assign rd_tag_c  = tag_q[rd_slot];

endmodule

// File: rtl/md5core_result_collector.sv
// Collects md5core result bursts into a ping-pong buffer and streams them out.
module md5core_result_collector
  import md5core_result_collector_pkg::*;
#(
  parameter int unsigned RESULT_WORDS = RESULT_WORDS_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [WORD_W-1:0] dout,
  input  logic              dout_en,
  input  logic              dout_seq_num,
  input  logic              dout_ctx_num,
  output logic [WORD_W-1:0] out_dout,
  output logic              out_valid,
  output logic              out_last,
  output logic              out_ctx_num,
  output logic              out_seq_num,
  input  logic              out_rd_en,
  output logic [FREE_W-1:0] slots_free,
  output logic              err_overflow,
  output logic              err_burst
);

  localparam int unsigned CNT_W = $clog2(RESULT_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RESULT_WORDS - 1);

  wr_state_e         state_q, state_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [SLOT_W-1:0] wr_slot_q, wr_slot_d;
  logic              err_overflow_d, err_burst_d;
  logic [CNT_W-1:0]  rd_cnt_q;
  logic [SLOT_W-1:0] rd_slot_q;

  logic                  buf_we_c, tag_we_c, set_full_c;
  logic                  rd_xfer_c, rd_last_c, slot_avail_c;
  logic [SLOT_COUNT-1:0] full;
  result_tag_t           in_tag_c, rd_tag_c;

  assign in_tag_c     = result_tag_t'{ctx: dout_ctx_num, seq: dout_seq_num};
  assign out_valid    = full[rd_slot_q];
  assign out_last     = out_valid & (rd_cnt_q == LAST_IDX);
  assign out_ctx_num  = rd_tag_c.ctx;
  assign out_seq_num  = rd_tag_c.seq;
  assign rd_xfer_c    = out_valid & out_rd_en;
  assign rd_last_c    = rd_xfer_c & (rd_cnt_q == LAST_IDX);
  // Target slot is usable if empty or being drained by its final read this cycle.
  assign slot_avail_c = !full[wr_slot_q] | (rd_last_c & (rd_slot_q == wr_slot_q));

  md5_result_buf #(
    .RESULT_WORDS (RESULT_WORDS)
  ) u_buf (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .wr_en     (buf_we_c),
    .wr_slot   (wr_slot_q),
    .wr_addr   (wr_cnt_q),
    .wr_data   (dout),
    .tag_en    (tag_we_c),
    .wr_tag    (in_tag_c),
    .set_full  (set_full_c),
    .clr_full  (rd_last_c),
    .rd_slot   (rd_slot_q),
    .rd_addr   (rd_cnt_q),
    .rd_data_c (out_dout),
    .rd_tag_c  (rd_tag_c),
    .full      (full)
  );

  // Write FSM state, counters and sticky error flags.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= WR_IDLE;
      wr_cnt_q     <= '0;
      wr_slot_q    <= '0;
      err_overflow <= 1'b0;
      err_burst    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      wr_slot_q    <= wr_slot_d;
      err_overflow <= err_overflow_d;
      err_burst    <= err_burst_d;
    end
  end

  // Write FSM next state: accept, fill, or drop a burst.
  always_comb begin
    state_d        = state_q;
    wr_cnt_d       = wr_cnt_q;
    wr_slot_d      = wr_slot_q;
    err_overflow_d = err_overflow;
    err_burst_d    = err_burst;
    buf_we_c       = 1'b0;
    tag_we_c       = 1'b0;
    set_full_c     = 1'b0;
    case (state_q)
      WR_IDLE: begin
        if (dout_en) begin
          wr_cnt_d = CNT_W'(1);
          if (slot_avail_c) begin
            buf_we_c = 1'b1;
            tag_we_c = 1'b1;
            state_d  = WR_FILL;
          end else begin
            err_overflow_d = 1'b1;
            state_d        = WR_DROP;
          end
        end
      end
      WR_FILL: begin
        if (dout_en) begin
          buf_we_c = 1'b1;
          if (wr_cnt_q == LAST_IDX) begin
            set_full_c = 1'b1;
            wr_slot_d  = ~wr_slot_q;
            wr_cnt_d   = '0;
            state_d    = WR_IDLE;
          end else begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
          end
        end else begin
          err_burst_d = 1'b1;
          wr_cnt_d    = '0;
          state_d     = WR_IDLE;
        end
      end
      WR_DROP: begin
        if (dout_en) begin
          if (wr_cnt_q == LAST_IDX) begin
            wr_cnt_d = '0;
            state_d  = WR_IDLE;
          end else begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
          end
        end else begin
          err_burst_d = 1'b1;
          wr_cnt_d    = '0;
          state_d     = WR_IDLE;
        end
      end
      default: begin
        wr_cnt_d = '0;
        state_d  = WR_IDLE;
      end
    endcase
  end

  // Read pointer and word counter advance on each accepted word.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_cnt_q  <= '0;
      rd_slot_q <= '0;
    end else if (rd_xfer_c) begin
      if (rd_last_c) begin
        rd_cnt_q  <= '0;
        rd_slot_q <= ~rd_slot_q;
      end else begin
        rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      end
    end
  end

  // Free-slot count, one cycle behind the full flags.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) slots_free <= FREE_W'(SLOT_COUNT);
    else        slots_free <= FREE_W'(SLOT_COUNT) - FREE_W'(full[0]) - FREE_W'(full[1]);
  end

endmodule

// File: tb/tb_md5core_result_collector.sv
// Scoreboard bench for md5core_result_collector with a queue-based reference model.
module tb_md5core_result_collector;

  localparam int unsigned RW = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic [31:0] dout = '0;
  logic        dout_en = 1'b0;
  logic        dout_seq_num = 1'b0;
  logic        dout_ctx_num = 1'b0;
  logic [31:0] out_dout;
  logic        out_valid;
  logic        out_last;
  logic        out_ctx_num;
  logic        out_seq_num;
  logic        out_rd_en = 1'b0;
  logic [1:0]  slots_free;
  logic        err_overflow;
  logic        err_burst;

  md5core_result_collector #(.RESULT_WORDS(RW)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .dout         (dout),
    .dout_en      (dout_en),
    .dout_seq_num (dout_seq_num),
    .dout_ctx_num (dout_ctx_num),
    .out_dout     (out_dout),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .out_ctx_num  (out_ctx_num),
    .out_seq_num  (out_seq_num),
    .out_rd_en    (out_rd_en),
    .slots_free   (slots_free),
    .err_overflow (err_overflow),
    .err_burst    (err_burst)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] w;
    logic        last;
    logic        ctx;
    logic        seq;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   chk_en = 1'b0;

  // Reference model: count of complete results held, words read from the head,
  // and the progress of the burst currently arriving (0 idle, 1 kept, 2 dropped).
  int          stored = 0;
  int          rd_idx = 0;
  int          mode = 0;
  int          cnt = 0;
  logic [31:0] cur_w [RW];
  logic        cur_ctx = 1'b0;
  logic        cur_seq = 1'b0;
  logic [1:0]  m_slots = 2'd2;
  logic        m_ovf = 1'b0;
  logic        m_burst = 1'b0;
  logic [31:0] bw [RW];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    stored = 0; rd_idx = 0; mode = 0; cnt = 0;
    m_slots = 2'd2; m_ovf = 1'b0; m_burst = 1'b0;
    exp_q.delete();
  endtask

  // Apply the effect of one clock edge given the inputs held during that cycle.
  task automatic model_edge(input logic en, input logic [31:0] d, input logic c,
                            input logic s, input logic rd);
    bit rd_x, last_r, done;
    exp_t e;
    rd_x   = (stored > 0) && rd;
    last_r = rd_x && (rd_idx == RW - 1);
    done   = 1'b0;
    m_slots = 2'(2 - stored);
    case (mode)
      0: if (en) begin
        cnt = 1;
        if (stored < 2 || last_r) begin
          mode = 1; cur_w[0] = d; cur_ctx = c; cur_seq = s;
        end else begin
          mode = 2; m_ovf = 1'b1;
        end
      end
      1: if (en) begin
        cur_w[cnt] = d; cnt++;
        if (cnt == RW) begin done = 1'b1; mode = 0; end
      end else begin
        m_burst = 1'b1; mode = 0;
      end
      default: if (en) begin
        cnt++;
        if (cnt == RW) mode = 0;
      end else begin
        m_burst = 1'b1; mode = 0;
      end
    endcase
    if (rd_x) begin
      rd_idx++;
      if (rd_idx == RW) begin rd_idx = 0; stored--; end
    end
    if (done) begin
      for (int i = 0; i < RW; i++) begin
        e.w = cur_w[i]; e.last = (i == RW - 1); e.ctx = cur_ctx; e.seq = cur_seq;
        exp_q.push_back(e);
      end
      stored++;
    end
  endtask

  // One clock cycle of stimulus; rdm 0/1 fixes out_rd_en, 2 randomises it.
  task automatic cycle(input logic en, input logic [31:0] d, input logic c,
                       input logic s, input int rdm);
    logic rd;
    rd = (rdm == 2) ? logic'($urandom_range(0, 99) < 60) : logic'(rdm == 1);
    dout_en = en; dout = d; dout_ctx_num = c; dout_seq_num = s; out_rd_en = rd;
    @(posedge CLK); #1;
    model_edge(en, d, c, s, rd);
  endtask

  task automatic burst(input int n, input logic c, input logic s, input int rdm);
    for (int i = 0; i < n; i++) cycle(1'b1, bw[i], c, s, rdm);
  endtask

  task automatic idle(input int n, input int rdm);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, rdm);
  endtask

  task automatic rand_words();
    for (int i = 0; i < RW; i++) bw[i] = $urandom;
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock edge.
  task automatic do_reset();
    chk_en = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    chk("rst out_valid", 32'(out_valid), 32'h0);
    chk("rst out_last", 32'(out_last), 32'h0);
    chk("rst out_dout", out_dout, 32'h0);
    chk("rst out_ctx_num", 32'(out_ctx_num), 32'h0);
    chk("rst out_seq_num", 32'(out_seq_num), 32'h0);
    chk("rst slots_free", 32'(slots_free), 32'h2);
    chk("rst err_overflow", 32'(err_overflow), 32'h0);
    chk("rst err_burst", 32'(err_burst), 32'h0);
    model_clear();
    dout_en = 1'b0; out_rd_en = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST_N = 1'b1;
    @(posedge CLK); #1;
    chk_en = 1'b1;
  endtask

  // Monitor: per-cycle status against the model, and word transfers against the scoreboard.
  always @(negedge CLK) begin
    if (chk_en && RST_N) begin
      chk("out_valid", 32'(out_valid), 32'(stored > 0));
      chk("out_last", 32'(out_last), 32'((stored > 0) && (rd_idx == RW - 1)));
      chk("slots_free", 32'(slots_free), 32'(m_slots));
      chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
      chk("err_burst", 32'(err_burst), 32'(m_burst));
      if (out_valid && out_rd_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected word", 32'(out_valid), 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_dout", out_dout, e.w);
          chk("word last", 32'(out_last), 32'(e.last));
          chk("out_ctx_num", 32'(out_ctx_num), 32'(e.ctx));
          chk("out_seq_num", 32'(out_seq_num), 32'(e.seq));
        end
      end
    end
  end

  initial begin
    do_reset();

    // Single burst, reader always ready.
    bw[0] = 32'h4d5d219e; bw[1] = 32'h0a38ffaf; bw[2] = 32'h87e11a6d; bw[3] = 32'h9aef84fa;
    burst(RW, 1'b0, 1'b0, 1);
    idle(8, 1);

    // Two back-to-back bursts held, then released.
    burst(RW, 1'b0, 1'b0, 0);
    bw[0] = 32'h40593c8c; bw[1] = $urandom; bw[2] = $urandom; bw[3] = $urandom;
    burst(RW, 1'b1, 1'b1, 0);
    idle(3, 0);
    idle(3 * RW, 1);

    // Overflow: third burst while both slots are full, then recovery.
    rand_words(); burst(RW, 1'b1, 1'b0, 0);
    rand_words(); burst(RW, 1'b0, 1'b1, 0);
    rand_words(); burst(RW, 1'b1, 1'b1, 0);
    idle(3, 0);
    idle(3 * RW, 1);
    rand_words(); burst(RW, 1'b0, 1'b1, 1);
    idle(8, 1);

    // Truncated burst.
    rand_words(); burst(3, 1'b1, 1'b0, 1);
    idle(6, 1);

    // Final read of slot 0 coincides with word 0 of a new burst into slot 0.
    do_reset();
    rand_words(); burst(RW, 1'b0, 1'b0, 0);
    rand_words(); burst(RW, 1'b1, 1'b1, 0);
    idle(2, 0);
    idle(RW - 1, 1);
    rand_words(); burst(RW, 1'b1, 1'b0, 1);
    idle(3 * RW, 1);

    // Reset asserted mid-burst, then a normal burst.
    rand_words(); burst(2, 1'b1, 1'b1, 1);
    do_reset();
    rand_words(); burst(RW, 1'b1, 1'b0, 1);
    idle(8, 1);

    // Randomised traffic with random back-pressure and occasional truncation.
    for (int b = 0; b < 80; b++) begin
      int n;
      int gap;
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, RW - 1)) : int'(RW);
      rand_words();
      burst(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2);
      gap = (n < RW) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 2));
      idle(gap, 2);
    end
    idle(3 * RW + 4, 1);

    chk("scoreboard empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
